// File: rtl/feature_index_counter.sv
// -----------------------------------------------------------------------------
// feature_index_counter
//
// Two-dimensional (row, col) index generator for the GCN feature-matrix
// datapath. A sweep visits every index of a FEATURE_ROWS x FEATURE_COLS matrix
// exactly once, in row-major (column is the inner axis) or column-major (row is
// the inner axis) order. The order is chosen by col_major when start is
// accepted.
//
// Ports:
//   clk        in   clock; all state updates on its rising edge
//   reset      in   synchronous active-high reset (highest priority)
//   start      in   begin a sweep; only acted on in IDLE
//   enable     in   consume the current index; only acted on in RUN
//   clear      in   synchronous abort to IDLE, no done pulse, mode kept
//   col_major  in   0 = column inner, 1 = row inner; latched on start
//   row_count  out  current row index
//   col_count  out  current column index
//   row_last   out  row_count == FEATURE_ROWS-1
//   col_last   out  col_count == FEATURE_COLS-1
//   tick       out  busy & enable: current index consumed this cycle
//   busy       out  sweep in progress (RUN)
//   done       out  one-cycle pulse after the final index is consumed
// -----------------------------------------------------------------------------
module feature_index_counter #(
  parameter int FEATURE_ROWS = 6,
  parameter int FEATURE_COLS = 96,
  parameter int ROW_WIDTH    = $clog2(FEATURE_ROWS),
  parameter int COL_WIDTH    = $clog2(FEATURE_COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 enable,
  input  logic                 clear,
  input  logic                 col_major,
  output logic [ROW_WIDTH-1:0] row_count,
  output logic [COL_WIDTH-1:0] col_count,
  output logic                 row_last,
  output logic                 col_last,
  output logic                 tick,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [ROW_WIDTH-1:0] ROW_MAX  = ROW_WIDTH'(FEATURE_ROWS - 1);
  localparam logic [COL_WIDTH-1:0] COL_MAX  = COL_WIDTH'(FEATURE_COLS - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_ZERO = {ROW_WIDTH{1'b0}};
  localparam logic [COL_WIDTH-1:0] COL_ZERO = {COL_WIDTH{1'b0}};
  localparam logic [ROW_WIDTH-1:0] ROW_ONE  = ROW_WIDTH'(1);
  localparam logic [COL_WIDTH-1:0] COL_ONE  = COL_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [ROW_WIDTH-1:0]   row_q, row_d;
  logic [COL_WIDTH-1:0]   col_q, col_d;
  logic                   mode_q, mode_d;   // latched col_major for the sweep
  logic                   row_last_s, col_last_s;

  assign row_last_s = (row_q == ROW_MAX);
  assign col_last_s = (col_q == COL_MAX);

  // Next-state logic: clear beats start/enable; reset is handled in the flop.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    mode_d  = mode_q;
    if (clear) begin
      state_d = ST_IDLE;
      row_d   = ROW_ZERO;
      col_d   = COL_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_d  = col_major;
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (enable) begin
            if (!mode_q) begin
              // Row-major: column is the inner axis.
              if (!col_last_s) begin
                col_d = col_q + COL_ONE;
              end else if (!row_last_s) begin
                col_d = COL_ZERO;
                row_d = row_q + ROW_ONE;
              end else begin
                col_d   = COL_ZERO;
                row_d   = ROW_ZERO;
                state_d = ST_DONE;
              end
            end else begin
              // Column-major: row is the inner axis.
              if (!row_last_s) begin
                row_d = row_q + ROW_ONE;
              end else if (!col_last_s) begin
                row_d = ROW_ZERO;
                col_d = col_q + COL_ONE;
              end else begin
                col_d   = COL_ZERO;
                row_d   = ROW_ZERO;
                state_d = ST_DONE;
              end
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          row_d   = ROW_ZERO;
          col_d   = COL_ZERO;
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= ROW_ZERO;
      col_q   <= COL_ZERO;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      mode_q  <= mode_d;
    end
  end

  // All outputs decode registered state; tick is qualified by the live enable.
  assign row_count = row_q;
  assign col_count = col_q;
  assign row_last  = row_last_s;
  assign col_last  = col_last_s;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign tick      = busy & enable;

endmodule

// File: tb/tb_feature_index_counter.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for feature_index_counter (3 x 4 matrix).
// The driver steps a sweep-position model: the k-th consumed index of a sweep
// is computed arithmetically from k and the order, pushed into a queue, and a
// negedge monitor pops and compares it whenever the DUT shows tick. Expected
// done cycles are queued the same way.
// -----------------------------------------------------------------------------
module tb_feature_index_counter;

  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);

  logic          clk = 1'b0;
  logic          reset = 1'b1, start = 1'b0, enable = 1'b0, clear = 1'b0, col_major = 1'b0;
  logic [RW-1:0] row_count;
  logic [CW-1:0] col_count;
  logic          row_last, col_last, tick, busy, done;

  always #5 clk = ~clk;

  feature_index_counter #(
    .FEATURE_ROWS(ROWS),
    .FEATURE_COLS(COLS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .enable    (enable),
    .clear     (clear),
    .col_major (col_major),
    .row_count (row_count),
    .col_count (col_count),
    .row_last  (row_last),
    .col_last  (col_last),
    .tick      (tick),
    .busy      (busy),
    .done      (done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int exp_row_q[$];
  int exp_col_q[$];
  int exp_done_q[$];

  // Reference model: 0 idle, 1 sweeping, 2 done-pulse cycle.
  int m_state = 0;
  int m_k     = 0;
  int m_mode  = 0;
  int m_busy  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: apply inputs, advance the model, wait past the edge.
  task automatic step(input bit s, input bit e, input bit c, input bit cm, input bit r);
    int er, ec;
    start = s; enable = e; clear = c; col_major = cm; reset = r;
    m_busy = (m_state == 1) ? 1 : 0;
    if (m_state == 1 && e) begin
      if (m_mode == 0) begin
        er = m_k / COLS; ec = m_k % COLS;
      end else begin
        er = m_k % ROWS; ec = m_k / ROWS;
      end
      exp_row_q.push_back(er);
      exp_col_q.push_back(ec);
    end
    if (r) begin
      m_state = 0; m_k = 0; m_mode = 0;
    end else if (c) begin
      m_state = 0; m_k = 0;
    end else begin
      case (m_state)
        0: if (s) begin m_state = 1; m_mode = cm ? 1 : 0; end
        1: if (e) begin
             m_k++;
             if (m_k == N) begin
               m_k = 0;
               m_state = 2;
               exp_done_q.push_back(cyc + 1);
             end
           end
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare presented index/flags against the scoreboard.
  always @(negedge clk) begin
    int er, ec, ed;
    chk("busy", busy, m_busy);
    if (tick) begin
      if (exp_row_q.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        er = exp_row_q.pop_front();
        ec = exp_col_q.pop_front();
        chk("tick_row", row_count, er);
        chk("tick_col", col_count, ec);
        chk("row_last", row_last, (er == ROWS - 1) ? 1 : 0);
        chk("col_last", col_last, (ec == COLS - 1) ? 1 : 0);
      end
    end
    if (done) begin
      if (exp_done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        ed = exp_done_q.pop_front();
        chk("done_cycle", cyc, ed);
        chk("done_row", row_count, 0);
        chk("done_col", col_count, 0);
      end
    end
  end

  initial begin
    int alt;
    int guard;

    // Reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("rst_row", row_count, 0);
    chk("rst_col", col_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    chk("rst_row_last", row_last, 0);
    chk("rst_col_last", col_last, 0);

    // Row-major sweep; start together with enable in IDLE
    step(1, 1, 0, 0, 0);
    chk("idle_en_row", row_count, 0);
    chk("idle_en_col", col_count, 0);
    chk("idle_en_busy", busy, 1);
    for (int i = 0; i < N; i++) step(0, 1, 0, 0, 0);
    chk("t1_done", done, 1);
    // start in the DONE cycle must be ignored
    step(1, 1, 0, 1, 0);
    chk("done_start_busy", busy, 0);
    chk("done_start_done", done, 0);
    step(0, 0, 0, 0, 0);
    chk("idle_after_done", busy, 0);

    // Column-major sweep with col_major toggling mid-sweep
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < N; i++) step(0, 1, 0, ($urandom % 2) == 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Row-major with alternating enable and random 3-cycle stalls
    step(1, 0, 0, 0, 0);
    alt = 1;
    guard = 0;
    while (m_state == 1 && guard < 200) begin
      if ($urandom_range(3, 0) == 0) begin
        repeat (3) step(0, 0, 0, 1, 0);
      end
      step(0, alt == 1, 0, 1, 0);
      alt = 1 - alt;
      guard++;
    end
    chk("stall_sweep_finished", m_state, 2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Clear at (1,2)
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    chk("pre_clear_row", row_count, 1);
    chk("pre_clear_col", col_count, 2);
    step(0, 1, 1, 0, 0);
    chk("clear_row", row_count, 0);
    chk("clear_col", col_count, 0);
    chk("clear_busy", busy, 0);
    chk("clear_done", done, 0);
    step(0, 0, 0, 0, 0);
    chk("clear_no_done", done, 0);
    // full sweep after clear
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Reset at (2,1) together with clear and enable
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 0);
    chk("pre_rst_row", row_count, 2);
    chk("pre_rst_col", col_count, 1);
    step(0, 1, 1, 0, 1);
    chk("mrst_row", row_count, 0);
    chk("mrst_col", col_count, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_tick", tick, 0);
    chk("mrst_row_last", row_last, 0);
    chk("mrst_col_last", col_last, 0);
    repeat (3) step(0, 0, 0, 0, 0);

    chk("ticks_left", exp_row_q.size(), 0);
    chk("dones_left", exp_done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/feature_index_counter.md
Name: feature_index_counter

Overview:
- Parametrised two-dimensional index generator for the GCN feature-matrix datapath.
- Sweeps (row, col) over a FEATURE_ROWS x FEATURE_COLS feature matrix, in row-major or column-major order.
- Provides a run/done handshake, per-axis last flags, a synchronous abort and a per-index strobe.
- Sits between the top-level GCN controller and the feature-memory address logic. Replaces single-axis row counters that had no control FSM.

Parameters:
- FEATURE_ROWS, 6, number of feature rows (must be >= 2)
- FEATURE_COLS, 96, number of feature columns (must be >= 2)
- ROW_WIDTH, $clog2(FEATURE_ROWS), width of the row index
- COL_WIDTH, $clog2(FEATURE_COLS), width of the column index

Ports:
- clk  input  1  single clock, all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; sampled only in IDLE
- enable  input  1  advance one index; sampled only in RUN
- clear  input  1  synchronous abort to IDLE; no done pulse
- col_major  input  1  0 = column is inner axis, 1 = row is inner axis; latched on accepted start
- row_count  output  ROW_WIDTH  current row index
- col_count  output  COL_WIDTH  current column index
- row_last  output  1  row_count == FEATURE_ROWS-1
- col_last  output  1  col_count == FEATURE_COLS-1
- tick  output  1  busy & enable: the current (row, col) is consumed this cycle
- busy  output  1  FSM in RUN
- done  output  1  one-cycle pulse after the final index is consumed

Behaviour:
- FSM states: IDLE, RUN, DONE. All registers update on posedge clk only.
- Priority each cycle: reset > clear > start/enable.
- Reset (synchronous, active-high), applied from any state, even mid-sweep:
  - state = IDLE, row_count = 0, col_count = 0, latched mode = 0.
  - Outputs: done = 0, busy = 0, tick = 0, row_last = 0, col_last = 0.
- IDLE:
  - start = 1: latch col_major, go to RUN. Counters are already 0, so the first index (0,0) is presented on the first RUN cycle.
  - enable is ignored in IDLE.
- RUN, enable = 0: hold all state.
- RUN, enable = 1, row-major (latched mode 0):
  - col not last: col += 1.
  - col last, row not last: col = 0, row += 1.
  - both last: row = 0, col = 0, go to DONE.
- RUN, enable = 1, column-major (latched mode 1): same as row-major with the axes swapped (row is inner).
- DONE: done = 1 for exactly this one cycle, then unconditionally go to IDLE. start, enable and col_major are ignored in DONE. Earliest restart is the cycle after DONE.
- start while in RUN is ignored. The latched mode does not change mid-sweep even if col_major toggles.
- clear in any state: state = IDLE, counters = 0, done = 0. Same effect as reset, except the latched mode is kept.
- Combinational outputs:
  - row_last and col_last decode the counter registers directly.
  - busy = (state == RUN).
  - tick = busy & enable.
  - done = (state == DONE).
- Timing: a full sweep consumes exactly FEATURE_ROWS*FEATURE_COLS ticks. done asserts the cycle after the final tick.
- Counters never take values >= their limit. The wrap from limit-1 to 0 is explicit, not natural overflow, so non-power-of-two sizes are correct.
- Pause handling: any number of enable = 0 cycles may occur in RUN with no effect on the index sequence.

Test Plan (FEATURE_ROWS = 3, FEATURE_COLS = 4):
- Reset, then start with col_major = 0, then enable held at 1 for 12 cycles → tick indices (0,0),(0,1),(0,2),(0,3),(1,0)…(2,3). done = 1 exactly one cycle after the 12th tick, counters read (0,0), busy = 0 on the following cycle.
- start with col_major = 1, enable held at 1 → index order (0,0),(1,0),(2,0),(0,1)…(2,3). done after the 12th tick. Toggling col_major mid-sweep does not change the order.
- Row-major sweep with enable alternating 1/0 and random 3-cycle stalls → same 12-index sequence. tick count = 12, and done is not asserted until the 12th tick.
- Assert clear at index (1,2) mid-sweep → next cycle IDLE, (0,0), busy = 0, no done pulse. A new start then sweeps the full 12 indices.
- Assert reset at index (2,1) together with clear and enable → next cycle IDLE, (0,0), all flags 0. Reset wins over clear.
- Boundary checks:
  - enable and start in IDLE → only start acts, index stays (0,0).
  - start asserted in the DONE cycle → ignored, FSM returns to IDLE.
  - At (2,3): row_last = 1 and col_last = 1.
